// File: rtl/axis_ilv_to_parallel_pkg.sv
// Shared helpers for the interleaved-to-parallel AXIS packer: slot counter sizing
// and mapping of a channel slot to its bit position in the packed beat.
package axis_ilv_to_parallel_pkg;

  function automatic int slot_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // ch0 sits in the MSBs, so slot k starts (NUM_CH-1-k) samples above bit 0
  function automatic int slot_lsb(input int slot, input int num_ch, input int data_w);
    return (num_ch - 1 - slot) * data_w;
  endfunction

endpackage

// File: rtl/axis_ilv_to_parallel_out_reg.sv
// Single-entry AXIS holding register: loads a packed beat with last/user and keeps it
// stable until the downstream handshake pops it.
module axis_ilv_to_parallel_out_reg #(
  parameter int W = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         load_user,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last,
  output logic         user
);

  // Load wins over pop so a same-cycle refill keeps valid high with no bubble
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid <= 1'b0;
      data  <= {W{1'b0}};
      last  <= 1'b0;
      user  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
      user  <= load_user;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_ilv_to_parallel.sv
// Packs NUM_CH time-interleaved AXIS samples into one wide beat (ch0 in the MSBs),
// realigning TLAST and padding/flagging groups cut short by an early TLAST.
module axis_ilv_to_parallel
  import axis_ilv_to_parallel_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter int                NUM_CH  = 2,
  parameter logic [DATA_W-1:0] PAD_VAL = {DATA_W{1'b0}}
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  output logic                     err_misalign
);

  localparam int                OUT_W     = NUM_CH * DATA_W;
  localparam int                SLOT_W    = slot_w(NUM_CH);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

  logic [SLOT_W-1:0] slot_r;
  logic [OUT_W-1:0]  acc_r;
  logic              err_r;
  logic [OUT_W-1:0]  beat_s;
  logic              m_valid_s;
  logic              last_slot_s;
  logic              out_free_s;
  logic              s_hs_s;
  logic              emit_s;
  logic              flush_s;

  assign last_slot_s   = (slot_r == LAST_SLOT);
  assign out_free_s    = !m_valid_s || m_axis_tready;
  // Only a beat that would complete a group needs room downstream
  assign s_axis_tready = (!last_slot_s && !s_axis_tlast) ? 1'b1 : out_free_s;
  assign s_hs_s        = s_axis_tvalid && s_axis_tready;
  assign emit_s        = s_hs_s && (last_slot_s || s_axis_tlast);
  assign flush_s       = s_hs_s && s_axis_tlast && !last_slot_s;

  // Assemble the outgoing beat: stored slots, the live sample, then padding
  always_comb begin
    beat_s = {OUT_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (i < int'(slot_r)) begin
        beat_s[slot_lsb(i, NUM_CH, DATA_W) +: DATA_W] = acc_r[slot_lsb(i, NUM_CH, DATA_W) +: DATA_W];
      end else if (i == int'(slot_r)) begin
        beat_s[slot_lsb(i, NUM_CH, DATA_W) +: DATA_W] = s_axis_tdata;
      end else begin
        beat_s[slot_lsb(i, NUM_CH, DATA_W) +: DATA_W] = PAD_VAL;
      end
    end
  end

  // Slot counter, accumulator and misalignment pulse
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      slot_r <= {SLOT_W{1'b0}};
      acc_r  <= {OUT_W{1'b0}};
      err_r  <= 1'b0;
    end else begin
      err_r <= flush_s;
      if (emit_s) begin
        slot_r <= {SLOT_W{1'b0}};
        acc_r  <= {OUT_W{1'b0}};
      end else if (s_hs_s) begin
        slot_r <= slot_r + SLOT_W'(1'b1);
        acc_r[slot_lsb(int'(slot_r), NUM_CH, DATA_W) +: DATA_W] <= s_axis_tdata;
      end
    end
  end

  axis_ilv_to_parallel_out_reg #(
    .W (OUT_W)
  ) u_out_reg (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (emit_s),
    .load_data (beat_s),
    .load_last (s_axis_tlast),
    .load_user (!last_slot_s),
    .pop       (m_axis_tready),
    .valid     (m_valid_s),
    .data      (m_axis_tdata),
    .last      (m_axis_tlast),
    .user      (m_axis_tuser)
  );

  assign m_axis_tvalid = m_valid_s;
  assign err_misalign  = err_r;

endmodule
